// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states and lane helpers.
// The ALIGN_CHK_EN macro (used by data_mem_ctrl) does not affect anything in this package.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_RSP = 2'd1,
    ST_RMW_WR   = 2'd2
  } state_t;

  // Size 11 is reserved and behaves as a word access.
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off2);
    logic [3:0] be;
    if (is_word(sz))
      be = 4'b1111;
    else if (sz == SZ_HALF)
      be = off2[1] ? 4'b1100 : 4'b0011;
    else
      be = 4'b0001 << off2;
    return be;
  endfunction

  // Copies the store lane into every position so the merge only needs byte enables.
  function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] data);
    logic [31:0] rep;
    if (is_word(sz))
      rep = data;
    else if (sz == SZ_HALF)
      rep = {data[15:0], data[15:0]};
    else
      rep = {4{data[7:0]}};
    return rep;
  endfunction

  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off2, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*off2 +: 8];
    h = off2[1] ? word[31:16] : word[15:0];
    if (is_word(sz))
      res = word;
    else if (sz == SZ_HALF)
      res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
    return res;
  endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word RAM with registered read; maps onto inferred block RAM.
// Read returns the previous contents when written in the same cycle.
module dmem_word_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_idx] <= i_wdata;
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: address decode, loads with extension, word stores and sub-word RMW.
// Define ALIGN_CHK_EN to reject misaligned half/word accesses instead of forcing alignment.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_ram_rena,
  input  logic        d_ram_wena,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  input  logic [2:0]  choice,
  output logic [31:0] Data_out,
  output logic        rdata_valid,
  output logic        d_ram_busy,
  output logic        addr_err
);

  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  state_t r_state, w_state_next;

  logic [31:0]      w_off;
  logic [1:0]       w_size;
  logic             w_uns;
  logic [1:0]       w_off2;
  logic             w_misalign;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_ready, w_ok, w_err, w_st, w_ld;

  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_idx;
  logic [31:0]      w_ram_wdata, w_ram_rdata, w_merged;

  logic [1:0]       r_off2;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_data_out;
  logic             r_rdata_valid;
  logic             r_addr_err;

  assign w_off      = DAddr - BASE_ADDR;
  assign w_in_range = {1'b0, w_off} < SPAN_BYTES;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_size     = choice[1:0];
  assign w_uns      = choice[2];

`ifdef ALIGN_CHK_EN
  assign w_off2     = w_off[1:0];
  assign w_misalign = (is_word(w_size) && (w_off[1:0] != 2'b00)) ||
                      ((w_size == SZ_HALF) && w_off[0]);
`else
  assign w_off2     = is_word(w_size)     ? 2'b00 :
                      (w_size == SZ_HALF) ? {w_off[1], 1'b0} : w_off[1:0];
  assign w_misalign = 1'b0;
`endif

  // Requests are only sampled outside the RMW write cycle.
  assign w_ready = (r_state != ST_RMW_WR);
  assign w_ok    = w_in_range && !w_misalign;
  assign w_err   = w_ready && (d_ram_wena || d_ram_rena) && !w_ok;
  assign w_st    = w_ready && d_ram_wena && w_ok;
  assign w_ld    = w_ready && !d_ram_wena && d_ram_rena && w_ok;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_LOAD_RSP: begin
        if (w_st && !is_word(w_size))
          w_state_next = ST_RMW_WR;
        else if (w_ld)
          w_state_next = ST_LOAD_RSP;
        else
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_idx   = w_idx;
    w_ram_wdata = DataIn;
    if (r_state == ST_RMW_WR) begin
      // A reset landing on the write cycle abandons the merge.
      w_ram_we    = !rst;
      w_ram_idx   = r_idx;
      w_ram_wdata = w_merged;
    end else begin
      w_ram_we    = w_st && is_word(w_size) && !rst;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8] : w_ram_rdata[8*gi +: 8];
    end
  endgenerate

  dmem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_idx   (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_st || w_ld) begin
      r_off2  <= w_off2;
      r_size  <= w_size;
      r_uns   <= w_uns;
      r_idx   <= w_idx;
      r_wdata <= lane_replicate(w_size, DataIn);
      r_be    <= byte_en(w_size, w_off2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out    <= 32'h0;
      r_rdata_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_rdata_valid <= (r_state == ST_LOAD_RSP);
      r_addr_err    <= w_err;
      if (r_state == ST_LOAD_RSP)
        r_data_out <= lane_extend(w_ram_rdata, r_size, r_off2, r_uns);
    end
  end

  assign Data_out    = r_data_out;
  assign rdata_valid = r_rdata_valid;
  assign d_ram_busy  = (r_state == ST_RMW_WR);
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl against a byte-addressed memory model.
// Expectations follow ALIGN_CHK_EN when the macro is defined for the build.
module tb_data_mem_ctrl;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_ram_rena, d_ram_wena;
  logic [31:0] DAddr, DataIn;
  logic [2:0]  choice;
  logic [31:0] Data_out;
  logic        rdata_valid, d_ram_busy, addr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdl [NBYTE];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .d_ram_rena(d_ram_rena), .d_ram_wena(d_ram_wena),
    .DAddr(DAddr), .DataIn(DataIn), .choice(choice), .Data_out(Data_out),
    .rdata_valid(rdata_valid), .d_ram_busy(d_ram_busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Byte address the access really touches (low bits dropped for half/word).
  function automatic int eff_off(input logic [31:0] off, input logic [2:0] ch);
    if (ch[1])           return int'(off & ~32'd3);
    else if (ch[0])      return int'(off & ~32'd1);
    else                 return int'(off);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] off, input logic [2:0] ch);
    int a;
    logic [15:0] h;
    logic [7:0]  b;
    a = eff_off(off, ch);
    if (ch[1]) return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
    h = {mdl[a+1], mdl[a]};
    b = mdl[a];
    if (ch[0]) return ch[2] ? {16'h0, h} : 32'($signed(h));
    return ch[2] ? {24'h0, b} : 32'($signed(b));
  endfunction

  task automatic mdl_store(input logic [31:0] off, input logic [2:0] ch, input logic [31:0] d);
    int a;
    int n;
    a = eff_off(off, ch);
    n = ch[1] ? 4 : (ch[0] ? 2 : 1);
    for (int k = 0; k < n; k++) mdl[a+k] = d[8*k +: 8];
  endtask

  task automatic idle_inputs();
    d_ram_wena = 1'b0;
    d_ram_rena = 1'b0;
  endtask

  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] ch, input string tag);
    logic [31:0] off;
    logic        mis, ok, err, is_st, is_ld, sub;
    logic [31:0] exp_ld;
    off = addr - BASE;
`ifdef ALIGN_CHK_EN
    mis = (ch[1] && off[1:0] != 2'b00) || (ch[1:0] == 2'b01 && off[0]);
`else
    mis = 1'b0;
`endif
    ok    = (off < 32'(NBYTE)) && !mis;
    err   = (we || re) && !ok;
    is_st = we && ok;
    is_ld = !we && re && ok;
    sub   = is_st && !ch[1];
    exp_ld = is_ld ? mdl_load(off, ch) : 32'h0;
    $display("%s: we=%b re=%b addr=%h data=%h ch=%b", tag, we, re, addr, data, ch);

    d_ram_wena = we; d_ram_rena = re; DAddr = addr; DataIn = data; choice = ch;
    @(posedge clk); #1;
    idle_inputs();
    chk({tag, " addr_err"}, 32'(addr_err), 32'(err));
    chk({tag, " busy"}, 32'(d_ram_busy), 32'(sub));
    chk({tag, " early valid"}, 32'(rdata_valid), 32'(0));
    if (sub) begin
      // Junk request while busy must be ignored.
      d_ram_wena = 1'b1; d_ram_rena = 1'b1;
      DAddr = BASE + $urandom_range(0, 63); DataIn = $urandom; choice = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      idle_inputs();
      chk({tag, " busy end"}, 32'(d_ram_busy), 32'(0));
      chk({tag, " junk err"}, 32'(addr_err), 32'(0));
      mdl_store(off, ch, data);
    end else if (is_st) begin
      mdl_store(off, ch, data);
    end
    if (is_ld) begin
      @(posedge clk); #1;
      chk({tag, " valid"}, 32'(rdata_valid), 32'(1));
      chk({tag, " data"}, Data_out, exp_ld);
    end
    @(posedge clk); #1;
    chk({tag, " valid off"}, 32'(rdata_valid), 32'(0));
    chk({tag, " err off"}, 32'(addr_err), 32'(0));
  endtask

  initial begin
    logic [31:0] exp_a, exp_b, off_sel;
    logic [2:0]  ch;
    int          r;

    rst = 1'b1; idle_inputs(); DAddr = 32'h0; DataIn = 32'h0; choice = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    chk("rst Data_out", Data_out, 32'h0);
    chk("rst valid", 32'(rdata_valid), 32'(0));
    chk("rst busy", 32'(d_ram_busy), 32'(0));
    chk("rst addr_err", 32'(addr_err), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < 16; w++) access(1'b1, 1'b0, BASE + 32'(4*w), $urandom, 3'b010, "init");
    for (int w = DEPTH - 4; w < DEPTH; w++) access(1'b1, 1'b0, BASE + 32'(4*w), $urandom, 3'b010, "init hi");

    access(1'b1, 1'b0, 32'h1001_0008, 32'h1234_5678, 3'b010, "t1 SW");
    access(1'b0, 1'b1, 32'h1001_0008, 32'h0, 3'b010, "t1 LW");
    access(1'b1, 1'b0, 32'h1001_0009, 32'h0000_00AB, 3'b000, "t2 SB");
    access(1'b0, 1'b1, 32'h1001_0008, 32'h0, 3'b010, "t2 LW");
    access(1'b0, 1'b1, 32'h1001_0009, 32'h0, 3'b000, "t2 LB");
    access(1'b0, 1'b1, 32'h1001_0009, 32'h0, 3'b100, "t2 LBU");
    access(1'b1, 1'b0, 32'h1001_000A, 32'h0000_8001, 3'b001, "t3 SH");
    access(1'b0, 1'b1, 32'h1001_000A, 32'h0, 3'b001, "t3 LH");
    access(1'b0, 1'b1, 32'h1001_000A, 32'h0, 3'b101, "t3 LHU");
    access(1'b0, 1'b1, 32'h1001_0008, 32'h0, 3'b010, "t3 LW");
    access(1'b0, 1'b1, 32'h0000_0004, 32'h0, 3'b010, "t4 LW low");
    access(1'b0, 1'b1, BASE + 32'(NBYTE), 32'h0, 3'b010, "t4 LW top");
    access(1'b1, 1'b0, BASE + 32'(NBYTE) + 32'd8, 32'hDEAD_BEEF, 3'b010, "t4 SW top");
    access(1'b0, 1'b1, BASE + 32'(NBYTE - 4), 32'h0, 3'b010, "t4 LW last");
    access(1'b0, 1'b1, 32'h1001_0008, 32'h0, 3'b010, "t4 LW chk");
    access(1'b1, 1'b1, 32'h1001_0000, 32'd12345, 3'b010, "t5 both");
    access(1'b0, 1'b1, 32'h1001_0000, 32'h0, 3'b010, "t5 LW");
    access(1'b1, 1'b1, 32'h1001_0003, 32'h0000_0055, 3'b000, "t5 both SB");
    access(1'b0, 1'b1, 32'h1001_0001, 32'h0, 3'b001, "t6 LH odd");
    access(1'b0, 1'b1, 32'h1001_0006, 32'h0, 3'b110, "t6 LW mis");
    access(1'b1, 1'b0, 32'h1001_0011, 32'h0000_7E7E, 3'b001, "t6 SH odd");
    access(1'b0, 1'b1, 32'h1001_0010, 32'h0, 3'b010, "t6 LW");

    // Back-to-back loads: second accepted while the first responds.
    exp_a = mdl_load(32'd4, 3'b010);
    exp_b = mdl_load(32'd9, 3'b100);
    $display("b2b: LW 0x10010004 then LBU 0x10010009");
    d_ram_rena = 1'b1; DAddr = BASE + 32'd4; choice = 3'b010;
    @(posedge clk); #1;
    DAddr = BASE + 32'd9; choice = 3'b100;
    @(posedge clk); #1;
    idle_inputs();
    chk("b2b valid a", 32'(rdata_valid), 32'(1));
    chk("b2b data a", Data_out, exp_a);
    @(posedge clk); #1;
    chk("b2b valid b", 32'(rdata_valid), 32'(1));
    chk("b2b data b", Data_out, exp_b);
    @(posedge clk); #1;
    chk("b2b valid off", 32'(rdata_valid), 32'(0));

    // Reset on the RMW write cycle must leave the word untouched.
    $display("rst-in-rmw: SB 0x10010004 aborted by reset");
    d_ram_wena = 1'b1; DAddr = BASE + 32'd4; DataIn = 32'h0000_00EE; choice = 3'b000;
    @(posedge clk); #1;
    idle_inputs();
    chk("rmw rst busy", 32'(d_ram_busy), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmw rst idle", 32'(d_ram_busy), 32'(0));
    chk("rmw rst dout", Data_out, 32'h0);
    access(1'b0, 1'b1, BASE + 32'd4, 32'h0, 3'b010, "rmw rst LW");

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      off_sel = ($urandom_range(0, 1) == 0) ? 32'(NBYTE) + $urandom_range(0, 63) : $urandom;
      else if (r == 1) off_sel = 32'(NBYTE - 16) + $urandom_range(0, 15);
      else             off_sel = $urandom_range(0, 63);
      ch = 3'($urandom_range(0, 7));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BASE + off_sel, $urandom, ch, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
